// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory access engine.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } memState_t;

   localparam int MEM_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port; master is the pipeline, slave is the memory.
interface mem_access_unit_if;

   logic        dmemReq;
   logic        dmemWe;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWdata;
   logic        dmemAck;
   logic [31:0] dmemRdata;

   modport master (
      output dmemReq, dmemWe, dmemAddr, dmemWdata,
      input  dmemAck, dmemRdata
   );

   modport slave (
      input  dmemReq, dmemWe, dmemAddr, dmemWdata,
      output dmemAck, dmemRdata
   );

endinterface

// File: rtl/mem_access_unit_memwb_reg.sv
// MEM/WB pipeline register; a bubble clears regWrite and holds every other field.
module memwb_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        bubble_i,
   input  logic        regWrite_i,
   input  logic        memToReg_i,
   input  logic [31:0] readData_i,
   input  logic [31:0] aluResult_i,
   input  logic [4:0]  rd_i,
   output logic        regWrite_o,
   output logic        memToReg_o,
   output logic [31:0] readData_o,
   output logic [31:0] aluResult_o,
   output logic [4:0]  rd_o
);

   logic        regWrite_q;
   logic        memToReg_q;
   logic [31:0] readData_q;
   logic [31:0] aluResult_q;
   logic [4:0]  rd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         regWrite_q  <= 1'b0;
         memToReg_q  <= 1'b0;
         readData_q  <= '0;
         aluResult_q <= '0;
         rd_q        <= '0;
      end else if (bubble_i) begin
         regWrite_q  <= 1'b0;
      end else begin
         regWrite_q  <= regWrite_i;
         memToReg_q  <= memToReg_i;
         readData_q  <= readData_i;
         aluResult_q <= aluResult_i;
         rd_q        <= rd_i;
      end
   end

   assign regWrite_o  = regWrite_q;
   assign memToReg_o  = memToReg_q;
   assign readData_o  = readData_q;
   assign aluResult_o = aluResult_q;
   assign rd_o        = rd_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage engine: issues one request/ack transaction per load/store, stalls the
// front of the pipeline meanwhile, and feeds the MEM/WB register.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               exmemRegWriteIn,
   input  logic               exmemMemToRegIn,
   input  logic               exmemMemReadIn,
   input  logic               exmemMemWriteIn,
   input  logic [31:0]        exmemAluResultIn,
   input  logic [31:0]        exmemMemoryDataIn,
   input  logic [4:0]         exmemRdIn,
   mem_access_unit_if.master  dmem,
   output logic               stall,
   output logic               busErr,
   output logic               memwbRegWriteOut,
   output logic               memwbMemToRegOut,
   output logic [31:0]        memwbReadDataOut,
   output logic [31:0]        memwbAluResultOut,
   output logic [4:0]         memwbRdOut
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   memState_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        busErr_q, busErr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [31:0] rdata_q, rdata_d;

   logic access;
   logic busy;

   assign access = exmemMemReadIn | exmemMemWriteIn;
   assign busy   = (state_q == BUSY);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busErr_d = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               addr_d  = exmemAluResultIn;
               wdata_d = exmemMemoryDataIn;
               we_d    = exmemMemWriteIn;   // read+write together behaves as a store
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Ack takes priority over an expiring timeout in the same cycle.
            if (dmem.dmemAck) begin
               rdata_d = we_q ? '0 : dmem.dmemRdata;
               state_d = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               busErr_d = 1'b1;
               rdata_d  = '0;
               state_d  = DONE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         busErr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busErr_q <= busErr_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
   end

   assign stall          = busy | ((state_q == IDLE) & access);
   assign busErr         = busErr_q;
   assign dmem.dmemReq   = busy;
   assign dmem.dmemWe    = busy & we_q;
   assign dmem.dmemAddr  = busy ? addr_q  : '0;
   assign dmem.dmemWdata = busy ? wdata_q : '0;

   memwb_reg u_memwb (
      .clk         (clk),
      .rst         (rst),
      .bubble_i    (stall),
      .regWrite_i  (exmemRegWriteIn),
      .memToReg_i  (exmemMemToRegIn),
      .readData_i  ((state_q == DONE) ? rdata_q : 32'h0),
      .aluResult_i (exmemAluResultIn),
      .rd_i        (exmemRdIn),
      .regWrite_o  (memwbRegWriteOut),
      .memToReg_o  (memwbMemToRegOut),
      .readData_o  (memwbReadDataOut),
      .aluResult_o (memwbAluResultOut),
      .rd_o        (memwbRdOut)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level expected timeline plus literal spot checks.
module tb_mem_access_unit;

   localparam int TO = 15;

   typedef struct packed {
      logic        rw;
      logic        mtr;
      logic [31:0] rdat;
      logic [31:0] alu;
      logic [4:0]  rd;
   } mw_t;

   logic        clk;
   logic        rst;
   logic        exmemRegWriteIn, exmemMemToRegIn, exmemMemReadIn, exmemMemWriteIn;
   logic [31:0] exmemAluResultIn, exmemMemoryDataIn;
   logic [4:0]  exmemRdIn;
   logic        stall, busErr;
   logic        memwbRegWriteOut, memwbMemToRegOut;
   logic [31:0] memwbReadDataOut, memwbAluResultOut;
   logic [4:0]  memwbRdOut;

   mem_access_unit_if dif ();

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk               (clk),
      .rst               (rst),
      .exmemRegWriteIn   (exmemRegWriteIn),
      .exmemMemToRegIn   (exmemMemToRegIn),
      .exmemMemReadIn    (exmemMemReadIn),
      .exmemMemWriteIn   (exmemMemWriteIn),
      .exmemAluResultIn  (exmemAluResultIn),
      .exmemMemoryDataIn (exmemMemoryDataIn),
      .exmemRdIn         (exmemRdIn),
      .dmem              (dif),
      .stall             (stall),
      .busErr            (busErr),
      .memwbRegWriteOut  (memwbRegWriteOut),
      .memwbMemToRegOut  (memwbMemToRegOut),
      .memwbReadDataOut  (memwbReadDataOut),
      .memwbAluResultOut (memwbAluResultOut),
      .memwbRdOut        (memwbRdOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int stall_cnt = 0;
   int req_cnt   = 0;
   int err_cnt   = 0;
   bit chk_en    = 1'b0;

   // Expected values for the current cycle.
   logic        e_stall, e_req, e_we, e_err;
   logic [31:0] e_addr, e_wdata;
   mw_t         e_mw, e_mw_nxt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      e_mw = e_mw_nxt;
   endtask

   task automatic set_quiet_exp();
      e_stall = 1'b0;
      e_req   = 1'b0;
      e_we    = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
      e_err   = 1'b0;
   endtask

   // One instruction held on EX/MEM until it retires. ack_k in 1..TO is the BUSY
   // cycle that sees the ack; any other value means the memory never answers.
   task automatic run_instr(input logic rw, input logic mtr, input logic mr, input logic mwr,
                            input logic [31:0] alu, input logic [31:0] data,
                            input logic [4:0] rd, input int ack_k, input logic [31:0] rdat);
      logic        timed_out;
      logic [31:0] cap;
      exmemRegWriteIn   = rw;
      exmemMemToRegIn   = mtr;
      exmemMemReadIn    = mr;
      exmemMemWriteIn   = mwr;
      exmemAluResultIn  = alu;
      exmemMemoryDataIn = data;
      exmemRdIn         = rd;
      dif.dmemAck       = 1'($urandom);
      dif.dmemRdata     = $urandom;
      set_quiet_exp();
      if (!(mr | mwr)) begin
         e_mw_nxt = '{rw, mtr, 32'h0, alu, rd};
         tick();
      end else begin
         e_stall  = 1'b1;
         e_mw_nxt = e_mw;
         e_mw_nxt.rw = 1'b0;
         tick();
         timed_out = 1'b1;
         for (int b = 1; b <= TO; b++) begin
            e_stall = 1'b1;
            e_req   = 1'b1;
            e_addr  = alu;
            e_wdata = data;
            e_we    = mwr;
            e_err   = 1'b0;
            dif.dmemAck   = (b == ack_k);
            dif.dmemRdata = (b == ack_k) ? rdat : $urandom;
            e_mw_nxt = e_mw;
            e_mw_nxt.rw = 1'b0;
            tick();
            if (b == ack_k) begin
               timed_out = 1'b0;
               break;
            end
         end
         cap = (timed_out || mwr) ? 32'h0 : rdat;
         set_quiet_exp();
         e_err         = timed_out;
         dif.dmemAck   = 1'($urandom);
         dif.dmemRdata = $urandom;
         e_mw_nxt = '{rw, mtr, cap, alu, rd};
         tick();
      end
   endtask

   task automatic zero_inputs();
      exmemRegWriteIn   = 1'b0;
      exmemMemToRegIn   = 1'b0;
      exmemMemReadIn    = 1'b0;
      exmemMemWriteIn   = 1'b0;
      exmemAluResultIn  = '0;
      exmemMemoryDataIn = '0;
      exmemRdIn         = '0;
   endtask

   initial begin
      int s0, r0, x0;
      logic mr, mwr;
      int kind, ack_k;

      fork
         forever begin
            @(negedge clk);
            if (chk_en) begin
               chk("stall",     32'(stall),             32'(e_stall));
               chk("dmemReq",   32'(dif.dmemReq),       32'(e_req));
               chk("dmemWe",    32'(dif.dmemWe),        32'(e_we));
               chk("dmemAddr",  dif.dmemAddr,           e_addr);
               chk("dmemWdata", dif.dmemWdata,          e_wdata);
               chk("busErr",    32'(busErr),            32'(e_err));
               chk("mw_rw",     32'(memwbRegWriteOut),  32'(e_mw.rw));
               chk("mw_mtr",    32'(memwbMemToRegOut),  32'(e_mw.mtr));
               chk("mw_rdata",  memwbReadDataOut,       e_mw.rdat);
               chk("mw_alu",    memwbAluResultOut,      e_mw.alu);
               chk("mw_rd",     32'(memwbRdOut),        32'(e_mw.rd));
               stall_cnt += int'(stall);
               req_cnt   += int'(dif.dmemReq);
               err_cnt   += int'(busErr);
            end
         end
      join_none

      rst = 1'b1;
      zero_inputs();
      dif.dmemAck   = 1'b0;
      dif.dmemRdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_req",   32'(dif.dmemReq), 32'h0);
      chk("rst_we",    32'(dif.dmemWe), 32'h0);
      chk("rst_addr",  dif.dmemAddr, 32'h0);
      chk("rst_wdata", dif.dmemWdata, 32'h0);
      chk("rst_err",   32'(busErr), 32'h0);
      chk("rst_mw",    {memwbAluResultOut[15:0], memwbReadDataOut[7:0], 3'b0,
                        memwbRdOut}, 32'h0);
      chk("rst_mwctl", 32'({memwbRegWriteOut, memwbMemToRegOut}), 32'h0);
      rst      = 1'b0;
      e_mw     = '0;
      e_mw_nxt = '0;
      set_quiet_exp();
      chk_en   = 1'b1;

      // ALU-only instruction
      s0 = stall_cnt;
      run_instr(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5, 0, 32'h0);
      chk("alu_res",   memwbAluResultOut, 32'h10);
      chk("alu_rd",    32'(memwbRdOut), 32'd5);
      chk("alu_rw",    32'(memwbRegWriteOut), 32'h1);
      chk("alu_stall", 32'(stall_cnt - s0), 32'd0);

      // Load acknowledged in the third BUSY cycle
      s0 = stall_cnt; r0 = req_cnt;
      run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, $urandom, 5'd7, 3, 32'hDEADBEEF);
      chk("ld_stall", 32'(stall_cnt - s0), 32'd4);
      chk("ld_req",   32'(req_cnt - r0), 32'd3);
      chk("ld_data",  memwbReadDataOut, 32'hDEADBEEF);
      chk("ld_mtr",   32'(memwbMemToRegOut), 32'h1);

      // Store acknowledged immediately
      s0 = stall_cnt; r0 = req_cnt;
      run_instr(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h1234, 5'd0, 1, $urandom);
      chk("st_stall", 32'(stall_cnt - s0), 32'd2);
      chk("st_req",   32'(req_cnt - r0), 32'd1);
      chk("st_rw",    32'(memwbRegWriteOut), 32'h0);

      // Timeout without any ack
      r0 = req_cnt; x0 = err_cnt;
      run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd9, 0, 32'hCAFEF00D);
      chk("to_req",  32'(req_cnt - r0), 32'd15);
      chk("to_err",  32'(err_cnt - x0), 32'd1);
      chk("to_data", memwbReadDataOut, 32'h0);

      // Ack coinciding with the last BUSY cycle
      r0 = req_cnt; x0 = err_cnt;
      run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 5'd10, TO, 32'h600DF00D);
      chk("late_req",  32'(req_cnt - r0), 32'd15);
      chk("late_err",  32'(err_cnt - x0), 32'd0);
      chk("late_data", memwbReadDataOut, 32'h600DF00D);

      // Reset during BUSY, followed by a stray ack
      exmemRegWriteIn  = 1'b1;
      exmemMemToRegIn  = 1'b1;
      exmemMemReadIn   = 1'b1;
      exmemMemWriteIn  = 1'b0;
      exmemAluResultIn = 32'h100;
      exmemMemoryDataIn = 32'h55;
      exmemRdIn        = 5'd3;
      dif.dmemAck      = 1'b0;
      set_quiet_exp();
      e_stall = 1'b1;
      e_mw_nxt = e_mw;
      e_mw_nxt.rw = 1'b0;
      tick();
      for (int b = 0; b < 2; b++) begin
         e_stall = 1'b1; e_req = 1'b1; e_addr = 32'h100; e_wdata = 32'h55; e_we = 1'b0;
         e_mw_nxt = e_mw;
         e_mw_nxt.rw = 1'b0;
         if (b == 1) begin
            rst = 1'b1;
            e_mw_nxt = '0;
         end
         tick();
      end
      rst = 1'b0;
      zero_inputs();
      set_quiet_exp();
      e_mw_nxt = '0;
      tick();
      dif.dmemAck   = 1'b1;
      dif.dmemRdata = 32'hBAD0BAD0;
      tick();
      tick();
      dif.dmemAck = 1'b0;
      chk("rstb_req",  32'(dif.dmemReq), 32'h0);
      chk("rstb_data", memwbReadDataOut, 32'h0);
      chk("rstb_rd",   32'(memwbRdOut), 32'h0);

      // Back-to-back loads with single-cycle acks
      r0 = req_cnt;
      run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 5'd11, 1, 32'h1111AAAA);
      chk("b2b_a", memwbReadDataOut, 32'h1111AAAA);
      run_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'hB0, 32'h0, 5'd12, 1, 32'h2222BBBB);
      chk("b2b_b",    memwbReadDataOut, 32'h2222BBBB);
      chk("b2b_rd",   32'(memwbRdOut), 32'd12);
      chk("b2b_reqs", 32'(req_cnt - r0), 32'd2);

      // Randomized instruction stream
      for (int i = 0; i < 80; i++) begin
         kind = int'($urandom_range(0, 9));
         mr   = (kind >= 4) && (kind != 7);
         mwr  = (kind >= 7);
         ack_k = int'($urandom_range(0, TO + 1));
         run_instr(1'($urandom), 1'($urandom), mr, mwr, $urandom, $urandom,
                   5'($urandom), ack_k, $urandom);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage access engine of the five-stage MIPS pipeline. It consumes the EX/MEM register outputs, runs a multi-cycle request/acknowledge transaction on the data-memory port for loads and stores, and stalls the front of the pipeline while a transaction is outstanding. It also contains the MEM/WB pipeline register, which it fills with either the ALU result or the returned load data.

## Interface
Parameters:
- TIMEOUT, 15: maximum BUSY cycles spent waiting for `dmemAck` before the access is abandoned.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- exmemRegWriteIn, exmemMemToRegIn, exmemMemReadIn, exmemMemWriteIn  in  1 each  control bits from EX/MEM.
- exmemAluResultIn  in  32  memory address or ALU result.
- exmemMemoryDataIn  in  32  store data.
- exmemRdIn  in  5  destination register.
- dmemReq  out  1  request valid.
- dmemWe  out  1  1 = store, 0 = load.
- dmemAddr  out  32  access address.
- dmemWdata  out  32  store data.
- dmemAck  in  1  memory completion.
- dmemRdata  in  32  load data, valid with `dmemAck`.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- busErr  out  1  one-cycle pulse on timeout.
- memwbRegWriteOut, memwbMemToRegOut  out  1 each  MEM/WB control bits.
- memwbReadDataOut, memwbAluResultOut  out  32 each  MEM/WB data.
- memwbRdOut  out  5  MEM/WB destination register.

## Operation
- Define `access = exmemMemReadIn | exmemMemWriteIn`. If both read and write are set, the access is treated as a store.
- State machine with three states: IDLE, BUSY, DONE.
- **IDLE, access = 0**
  - `stall = 0`.
  - MEM/WB captures the EX/MEM fields, with readData = 0.
- **IDLE, access = 1**
  - `stall = 1`.
  - Latch address, store data and we into internal registers.
  - Clear the timeout counter and go to BUSY.
  - MEM/WB captures a bubble: regWrite = 0, all other fields unchanged.
- **BUSY**
  - `dmemReq = 1`, `stall = 1`.
  - `dmemAddr`, `dmemWdata` and `dmemWe` are driven from the latched registers and stay stable until the access completes.
  - On `dmemAck`: capture `dmemRdata` (loads only) and go to DONE.
  - Otherwise, when the counter equals TIMEOUT-1: set the error flag, set captured data to 0 and go to DONE.
  - Otherwise: increment the counter.
  - If `dmemAck` arrives in the same cycle as the timeout, the ack wins and there is no error.
  - MEM/WB captures a bubble every BUSY cycle.
- **DONE**
  - `stall = 0`; `busErr` is 1 if the error flag is set.
  - MEM/WB captures the EX/MEM control fields, aluResult, rd, and readData = captured data.
  - Next state is IDLE. EX/MEM advances on this same edge, so the next instruction is evaluated fresh in IDLE and the completed access is never re-issued.
- `dmemAck` is ignored in IDLE and DONE.
- `dmemReq`, `dmemAddr`, `dmemWdata` and `dmemWe` are 0 outside BUSY.
- Timeout counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset (synchronous): state = IDLE, counter = 0, error flag = 0, all MEM/WB outputs = 0. As a result `stall`, `dmemReq`, `dmemWe`, `busErr` = 0 and `dmemAddr`, `dmemWdata` = 0 in the following cycle.
- Non-memory instruction: zero stall cycles. MEM/WB outputs are valid one edge after EX/MEM.
- Memory access with ack in BUSY cycle k (k ≥ 1): `stall` is high for 1 + k cycles.
  - Result appears on MEM/WB outputs after the DONE-cycle edge.
  - Minimum total is 2 stall cycles.
- Timeout: exactly TIMEOUT BUSY cycles, then DONE with `busErr` = 1 for one cycle.
- Reset mid-BUSY: the transaction is abandoned and `dmemReq` is 0 in the cycle after the reset edge. A late ack is ignored.
- `stall` and the `dmem*` outputs are combinational from state plus the EX/MEM inputs. `busErr` and the MEM/WB outputs are registered.

## Structure
- Package `mem_pkg`:
  - enum `memState_t` {IDLE, BUSY, DONE}
  - constant `MEM_TIMEOUT_DEFAULT` = 15
- Sub-module `memwb_reg`:
  - MEM/WB pipeline register with a `bubble` input that forces regWrite to 0, plus synchronous reset.
  - It is instantiated once; the FSM, counter and dmem drivers live in the top.

## Test plan
- **ALU-only instruction:** regWrite = 1, aluResult = 0x10, rd = 5, memRead = memWrite = 0 → `stall` = 0; after one edge memwbAluResultOut = 0x10, memwbRdOut = 5, memwbRegWriteOut = 1.
- **Load with ack in 3rd BUSY cycle:** address 0x40, `dmemAck` in BUSY cycle 3 with rdata 0xDEADBEEF → `stall` high for 4 cycles; dmemAddr = 0x40 and dmemWe = 0 throughout BUSY; memwbReadDataOut = 0xDEADBEEF and memToReg = 1 after DONE.
- **Store with immediate ack:** address 0x80, data 0x1234, ack in BUSY cycle 1 → dmemWe = 1, dmemWdata = 0x1234; `stall` high for 2 cycles; memwbRegWriteOut = 0.
- **Timeout:** load, no ack, TIMEOUT = 15 → `dmemReq` high for exactly 15 cycles; busErr = 1 for one cycle; memwbReadDataOut = 0. A second variant with ack coinciding with the last BUSY cycle gives busErr = 0 and the returned data.
- **Reset mid-BUSY:** rst for 1 cycle during BUSY → next cycle `dmemReq` = 0, `stall` = 0, all MEM/WB outputs = 0; an ack 2 cycles later causes no change.
- **Back-to-back loads:** two loads, ack after 1 cycle each → two distinct requests (addresses A then B); exactly one IDLE cycle between them; each `dmemReq` period is 1 cycle; both results appear on MEM/WB in order.
